// File: rtl/pc_gen_bp.sv
// Fetch PC register with next-PC prediction from a direct-mapped BTB with 2-bit counters.
// Resolution from EX corrects mispredictions through a combinational redirect.
module pc_gen_bp #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned BTB_DEPTH = 16,
   parameter int unsigned IDX_W     = $clog2(BTB_DEPTH),
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            cpu_clk,
   input  logic            cpu_rst,
   input  logic            stall,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc4,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_is_br,
   input  logic            ex_is_jmp,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc
);

   localparam int unsigned TAG_W = XLEN - IDX_W - 2;

   logic [XLEN-1:0]  pc_q, pc_d;
   logic             valid_q [BTB_DEPTH];
   logic             jflag_q [BTB_DEPTH];
   logic [1:0]       ctr_q   [BTB_DEPTH];
   logic [TAG_W-1:0] tag_q   [BTB_DEPTH];
   logic [XLEN-1:0]  tgt_q   [BTB_DEPTH];

   logic [IDX_W-1:0] f_idx, ex_idx;
   logic [TAG_W-1:0] f_tag, ex_tag;
   logic             f_hit, ex_hit, ctl, mis;
   logic             unused_lsb;

   assign unused_lsb = ^{pc_q[1:0], ex_pc[1:0]};

   // Lookup
   assign f_idx = pc_q[IDX_W+1:2];
   assign f_tag = pc_q[XLEN-1:IDX_W+2];
   assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

   assign pc          = pc_q;
   assign pc4         = pc_q + XLEN'(4);
   assign pred_taken  = f_hit && (jflag_q[f_idx] || ctr_q[f_idx][1]);
   assign pred_target = pred_taken ? tgt_q[f_idx] : pc4;

   // Resolution
   assign ctl = ex_is_br || ex_is_jmp;
   always_comb begin
      mis = 1'b0;
      if (ex_valid) begin
         if (ctl) begin
            mis = (ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target));
         end else begin
            mis = ex_pred_taken;
         end
      end
   end

   assign redirect    = mis;
   assign redirect_pc = (ctl && ex_taken) ? ex_target : ex_pc + XLEN'(4);

   always_comb begin
      pc_d = pred_target;
      if (mis) begin
         pc_d = redirect_pc;
      end else if (stall) begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // BTB update
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign ex_tag = ex_pc[XLEN-1:IDX_W+2];
   assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         for (int i = 0; i < int'(BTB_DEPTH); i++) begin
            valid_q[i] <= 1'b0;
            jflag_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
         end
      end else if (ex_valid) begin
         if (ex_is_jmp) begin
            valid_q[ex_idx] <= 1'b1;
            tag_q[ex_idx]   <= ex_tag;
            tgt_q[ex_idx]   <= ex_target;
            jflag_q[ex_idx] <= 1'b1;
         end else if (ex_is_br) begin
            if (ex_hit) begin
               if (ex_taken) begin
                  ctr_q[ex_idx] <= (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
                  tgt_q[ex_idx] <= ex_target;
               end else begin
                  ctr_q[ex_idx] <= (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
               end
            end else if (ex_taken) begin
               valid_q[ex_idx] <= 1'b1;
               tag_q[ex_idx]   <= ex_tag;
               tgt_q[ex_idx]   <= ex_target;
               jflag_q[ex_idx] <= 1'b0;
               ctr_q[ex_idx]   <= 2'b10;
            end
         end else if (ex_hit) begin
            // A non-control instruction matched: the entry is a stale alias.
            valid_q[ex_idx] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pc_gen_bp.sv
// Self-checking bench for pc_gen_bp: directed scenarios followed by random traffic,
// all checked against an address-level reference model of fetch and BTB behaviour.
module tb_pc_gen_bp;

   localparam int XLEN  = 32;
   localparam int DEPTH = 16;
   localparam int IW    = $clog2(DEPTH);
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        cpu_clk, cpu_rst, stall;
   logic [31:0] pc, pc4, pred_target, ex_pc, ex_target, ex_pred_target, redirect_pc;
   logic        pred_taken, ex_valid, ex_is_br, ex_is_jmp, ex_taken, ex_pred_taken, redirect;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [31:0] m_pc;
   bit          m_v   [DEPTH];
   bit          m_j   [DEPTH];
   int          m_c   [DEPTH];
   logic [31:0] m_tag [DEPTH];
   logic [31:0] m_tgt [DEPTH];

   logic [31:0] pool [8] = '{32'h10, 32'h50, 32'h20, 32'h60, 32'h14, 32'h1C, 32'h100,
                             32'hFFFF_FFFC};

   pc_gen_bp #(
      .XLEN(XLEN),
      .BTB_DEPTH(DEPTH),
      .RESET_PC(RPC)
   ) dut (
      .cpu_clk(cpu_clk),
      .cpu_rst(cpu_rst),
      .stall(stall),
      .pc(pc),
      .pc4(pc4),
      .pred_taken(pred_taken),
      .pred_target(pred_target),
      .ex_valid(ex_valid),
      .ex_pc(ex_pc),
      .ex_is_br(ex_is_br),
      .ex_is_jmp(ex_is_jmp),
      .ex_taken(ex_taken),
      .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken),
      .ex_pred_target(ex_pred_target),
      .redirect(redirect),
      .redirect_pc(redirect_pc)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int midx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   function automatic logic [31:0] mtag(input logic [31:0] a);
      return a >> (2 + IW);
   endfunction

   task automatic m_reset();
      m_pc = RPC;
      for (int i = 0; i < DEPTH; i++) begin
         m_v[i] = 0;
         m_j[i] = 0;
         m_c[i] = 1;
      end
   endtask

   task automatic idle();
      stall = 0; ex_valid = 0; ex_pc = '0; ex_is_br = 0; ex_is_jmp = 0; ex_taken = 0;
      ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
   endtask

   // Check all outputs against the model, clock once, advance the model.
   task automatic step();
      int          i, ei;
      bit          hit, ehit, e_pt, is_ctl, mis;
      logic [31:0] e_tgt, e_rpc;
      #1;
      i     = midx(m_pc);
      hit   = m_v[i] && (m_tag[i] == mtag(m_pc));
      e_pt  = hit && (m_j[i] || m_c[i] >= 2);
      e_tgt = e_pt ? m_tgt[i] : m_pc + 32'd4;
      is_ctl = ex_is_br || ex_is_jmp;
      if (!ex_valid) mis = 0;
      else if (is_ctl) mis = (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target);
      else mis = ex_pred_taken;
      e_rpc = (is_ctl && ex_taken) ? ex_target : ex_pc + 32'd4;
      chk("pc", pc, m_pc);
      chk("pc4", pc4, m_pc + 32'd4);
      chk("pred_taken", {31'b0, pred_taken}, {31'b0, e_pt});
      chk("pred_target", pred_target, e_tgt);
      chk("redirect", {31'b0, redirect}, {31'b0, mis});
      chk("redirect_pc", redirect_pc, e_rpc);
      @(posedge cpu_clk);
      if (mis) m_pc = e_rpc;
      else if (!stall) m_pc = e_tgt;
      if (ex_valid) begin
         ei   = midx(ex_pc);
         ehit = m_v[ei] && (m_tag[ei] == mtag(ex_pc));
         if (ex_is_jmp) begin
            m_v[ei] = 1; m_tag[ei] = mtag(ex_pc); m_tgt[ei] = ex_target; m_j[ei] = 1;
         end else if (ex_is_br) begin
            if (ehit) begin
               if (ex_taken) begin
                  m_c[ei] = (m_c[ei] == 3) ? 3 : m_c[ei] + 1;
                  m_tgt[ei] = ex_target;
               end else begin
                  m_c[ei] = (m_c[ei] == 0) ? 0 : m_c[ei] - 1;
               end
            end else if (ex_taken) begin
               m_v[ei] = 1; m_tag[ei] = mtag(ex_pc); m_tgt[ei] = ex_target;
               m_j[ei] = 0; m_c[ei] = 2;
            end
         end else if (ehit) begin
            m_v[ei] = 0;
         end
      end
      #1;
   endtask

   task automatic resolve(input bit br, input bit jmp, input logic [31:0] a, input bit tk,
                          input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
      ex_valid = 1; ex_is_br = br; ex_is_jmp = jmp; ex_pc = a; ex_taken = tk;
      ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
   endtask

   // Steer fetch to address a using a mispredicted non-control instruction at a-4.
   task automatic redirect_to(input logic [31:0] a);
      resolve(0, 0, a - 32'd4, 0, '0, 1, '0);
      step();
      idle();
      chk("redirect_to_pc", pc, a);
   endtask

   initial begin
      idle();
      cpu_rst = 1;
      m_reset();
      #12;
      chk("rst_pc", pc, RPC);
      chk("rst_pc4", pc4, RPC + 32'd4);
      chk("rst_pred", {31'b0, pred_taken}, 32'd0);
      chk("rst_redirect", {31'b0, redirect}, 32'd0);
      @(posedge cpu_clk);
      #1 cpu_rst = 0;

      // Sequential fetch
      for (int k = 0; k < 4; k++) step();
      chk("seq_pc", pc, 32'h10);

      // Taken branch 0x10 -> 0x40, predicted not-taken
      resolve(1, 0, 32'h10, 1, 32'h40, 0, 32'h14);
      #1;
      chk("br_redirect", {31'b0, redirect}, 32'd1);
      chk("br_redirect_pc", redirect_pc, 32'h40);
      step();
      idle();
      chk("br_pc", pc, 32'h40);
      redirect_to(32'h10);
      chk("br_pred_taken", {31'b0, pred_taken}, 32'd1);
      chk("br_pred_target", pred_target, 32'h40);
      step();

      // Two not-taken resolutions: counter 10 -> 01 -> 00
      resolve(1, 0, 32'h10, 0, 32'h40, 1, 32'h40);
      #1;
      chk("nt_redirect_pc", redirect_pc, 32'h14);
      step();
      resolve(1, 0, 32'h10, 0, 32'h40, 0, 32'h14);
      step();
      idle();
      redirect_to(32'h10);
      chk("nt_pred_taken", {31'b0, pred_taken}, 32'd0);
      step();

      // Jump 0x20 -> 0x100 while stalled: redirect wins
      resolve(0, 1, 32'h20, 1, 32'h100, 0, 32'h24);
      stall = 1;
      step();
      idle();
      chk("jmp_pc", pc, 32'h100);
      redirect_to(32'h20);
      chk("jmp_pred_taken", {31'b0, pred_taken}, 32'd1);
      chk("jmp_pred_target", pred_target, 32'h100);
      step();

      // Aliasing: 0x50 shares the index of 0x10
      resolve(1, 0, 32'h10, 1, 32'h40, 0, 32'h14);
      step();
      resolve(1, 0, 32'h50, 1, 32'h80, 0, 32'h54);
      step();
      idle();
      redirect_to(32'h10);
      chk("alias_old_miss", {31'b0, pred_taken}, 32'd0);
      step();
      redirect_to(32'h50);
      chk("alias_new_hit", {31'b0, pred_taken}, 32'd1);
      chk("alias_new_tgt", pred_target, 32'h80);
      step();

      // Wrap-around
      redirect_to(32'hFFFF_FFFC);
      step();
      chk("wrap_pc", pc, 32'h0);

      // Mid-stream reset with an update pending on the edge
      resolve(1, 0, 32'h50, 1, 32'h90, 0, 32'h54);
      #2 cpu_rst = 1;
      #1;
      chk("midrst_pc", pc, RPC);
      chk("midrst_pred", {31'b0, pred_taken}, 32'd0);
      @(posedge cpu_clk);
      #1 cpu_rst = 0;
      idle();
      m_reset();
      redirect_to(32'h50);
      chk("midrst_miss", {31'b0, pred_taken}, 32'd0);
      step();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         int kind;
         idle();
         stall    = ($urandom % 4) == 0;
         ex_valid = $urandom % 2;
         kind     = $urandom % 3;
         ex_pc    = pool[$urandom % 8];
         ex_is_br  = (kind == 1);
         ex_is_jmp = (kind == 2);
         ex_target = pool[$urandom % 8];
         ex_taken  = ex_is_jmp ? 1'b1 : 1'($urandom % 2);
         ex_pred_taken  = $urandom % 2;
         ex_pred_target = ($urandom % 2) ? ex_target : pool[$urandom % 8];
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
